// File: rtl/inst_encoder_if.sv
// Request/response bundle for the RV32I instruction encoder.
// The slave modport is the encoder's view; the master modport is the requester/consumer view.
interface inst_encoder_if #(
    parameter int unsigned CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [6:0]       in_opcode;
    logic [4:0]       in_rd;
    logic [4:0]       in_rs1;
    logic [4:0]       in_rs2;
    logic [2:0]       in_funct3;
    logic [6:0]       in_funct7;
    logic [11:0]      in_csr_addr;
    logic [31:0]      in_imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_inst;
    logic             out_last;
    logic             out_err;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7,
               in_csr_addr, in_imm, out_ready,
        input  in_ready, out_valid, out_inst, out_last, out_err, err_cnt
    );

    modport slave (
        input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7,
               in_csr_addr, in_imm, out_ready,
        output in_ready, out_valid, out_inst, out_last, out_err, err_cnt
    );
endinterface

// File: rtl/inst_encoder.sv
// Packs decoded RV32I fields and an architectural immediate into an instruction word.
// Out-of-range x0-based ADDI expands into LUI+ADDI; unencodable requests emit a flagged NOP.
module inst_encoder #(
    parameter int unsigned CNT_W = 8
) (
    input logic           clk,
    input logic           rst_n,
    inst_encoder_if.slave bus
);
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpSystem = 7'b1110011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [31:0] Nop     = 32'h0000_0013;

    typedef enum logic [0:0] {StIdle, StExp2} state_e;

    state_e           state_q;
    logic             out_valid_q, out_last_q, out_err_q;
    logic [31:0]      out_inst_q, pend_q;
    logic [CNT_W-1:0] err_cnt_q;

    logic [31:0] imm, enc, word2;
    logic [19:0] hi;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        expand, err, sext12, sext13, sext21, in_ready, accept;

    always_comb begin
        imm    = bus.in_imm;
        op     = bus.in_opcode;
        rd     = bus.in_rd;
        rs1    = bus.in_rs1;
        rs2    = bus.in_rs2;
        f3     = bus.in_funct3;
        enc    = Nop;
        word2  = '0;
        expand = 1'b0;
        err    = 1'b0;
        sext12 = (&imm[31:11]) | ~(|imm[31:11]);
        sext13 = (&imm[31:12]) | ~(|imm[31:12]);
        sext21 = (&imm[31:20]) | ~(|imm[31:20]);
        // Round the upper part so the sign-extended ADDI low half lands back on imm.
        hi     = imm[31:12] + {19'd0, imm[11]};
        case (op)
            OpImm, OpLoad, OpJalr: begin
                if (sext12) begin
                    enc = {imm[11:0], rs1, f3, rd, op};
                end else if (op == OpImm && f3 == 3'b000 && rs1 == 5'd0) begin
                    expand = 1'b1;
                    enc    = {hi, rd, OpLui};
                    word2  = {imm[11:0], rd, 3'b000, rd, OpImm};
                end else begin
                    err = 1'b1;
                end
            end
            OpStore: begin
                if (sext12) enc = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
                else        err = 1'b1;
            end
            OpBranch: begin
                if (sext13 && !imm[0]) begin
                    enc = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
                end else begin
                    err = 1'b1;
                end
            end
            OpLui, OpAuipc: begin
                if (imm[11:0] == 12'd0) enc = {imm[31:12], rd, op};
                else                    err = 1'b1;
            end
            OpJal: begin
                if (sext21 && !imm[0]) enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
                else                   err = 1'b1;
            end
            OpSystem: begin
                if (!f3[2])                   enc = {bus.in_csr_addr, rs1, f3, rd, op};
                else if (imm[31:5] == 27'd0)  enc = {bus.in_csr_addr, imm[4:0], f3, rd, op};
                else                          err = 1'b1;
            end
            OpReg:   enc = {bus.in_funct7, rs2, rs1, f3, rd, op};
            default: err = 1'b1;
        endcase
    end

    always_comb begin
        in_ready = (state_q == StIdle) && (!out_valid_q || bus.out_ready);
        accept   = bus.in_valid && in_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            out_inst_q  <= '0;
            out_last_q  <= 1'b0;
            out_err_q   <= 1'b0;
            pend_q      <= '0;
            err_cnt_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        out_valid_q <= 1'b1;
                        out_inst_q  <= enc;
                        out_last_q  <= !expand;
                        out_err_q   <= err;
                        if (expand) begin
                            pend_q  <= word2;
                            state_q <= StExp2;
                        end
                        if (err && err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_W'(1);
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                StExp2: begin
                    // Word 1 is always valid here; its consumption promotes word 2.
                    if (bus.out_ready) begin
                        out_inst_q <= pend_q;
                        out_last_q <= 1'b1;
                        out_err_q  <= 1'b0;
                        pend_q     <= '0;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_inst  = out_inst_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_err   = out_err_q;
    assign bus.err_cnt   = err_cnt_q;
endmodule
